// File: rtl/imem_loader_pkg.sv
// Shared constants and loader state encoding for the instruction-memory loader.
// Instructions are fetched big-endian as two bytes at PC, PC+1.
package imem_pkg;

    localparam int IMEM_ADDR_W = 8;
    localparam int INSTR_W     = 16;

    typedef enum logic [2:0] {
        IDLE,
        LEN,
        DATA,
        CSUM,
        DONE
    } loader_state_t;

endpackage

// File: rtl/imem_loader.sv
// Loads a framed byte stream (LEN, N data bytes, XOR CSUM) into the instruction
// memory write port, holding the CPU until the frame completes.
module imem_loader
    import imem_pkg::*;
#(
    parameter int                 ADDR_W    = IMEM_ADDR_W,
    parameter logic [ADDR_W-1:0]  BASE_ADDR = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [7:0]        in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_wdata,
    output logic              cpu_hold,
    output logic              done,
    output logic              err
);

    // One extra bit so a full-depth frame (LEN=0) fits in the counter.
    localparam int              CNT_W = ADDR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH = CNT_W'(1) << ADDR_W;

    loader_state_t     r_state, w_state_nxt;
    logic [CNT_W-1:0]  r_count, w_count_nxt;
    logic [7:0]        r_csum, w_csum_nxt;
    logic [ADDR_W-1:0] r_addr, w_addr_nxt;
    logic              r_odd, w_odd_nxt;
    logic              r_in_ready, w_in_ready_nxt;
    logic              r_we, w_we_nxt;
    logic [ADDR_W-1:0] r_maddr, w_maddr_nxt;
    logic [7:0]        r_wdata, w_wdata_nxt;
    logic              r_hold, w_hold_nxt;
    logic              r_done, w_done_nxt;
    logic              r_err, w_err_nxt;
    logic              w_xfer;

    assign w_xfer = in_valid && r_in_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_count    <= '0;
            r_csum     <= '0;
            r_addr     <= BASE_ADDR;
            r_odd      <= 1'b0;
            r_in_ready <= 1'b0;
            r_we       <= 1'b0;
            r_maddr    <= BASE_ADDR;
            r_wdata    <= '0;
            r_hold     <= 1'b0;
            r_done     <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_count    <= w_count_nxt;
            r_csum     <= w_csum_nxt;
            r_addr     <= w_addr_nxt;
            r_odd      <= w_odd_nxt;
            r_in_ready <= w_in_ready_nxt;
            r_we       <= w_we_nxt;
            r_maddr    <= w_maddr_nxt;
            r_wdata    <= w_wdata_nxt;
            r_hold     <= w_hold_nxt;
            r_done     <= w_done_nxt;
            r_err      <= w_err_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_count_nxt = r_count;
        w_csum_nxt  = r_csum;
        w_addr_nxt  = r_addr;
        w_odd_nxt   = r_odd;
        w_we_nxt    = 1'b0;
        w_maddr_nxt = r_maddr;
        w_wdata_nxt = r_wdata;
        w_hold_nxt  = r_hold;
        w_done_nxt  = 1'b0;
        w_err_nxt   = r_err;

        case (r_state)
            IDLE: begin
                if (start) begin
                    w_state_nxt = LEN;
                    w_hold_nxt  = 1'b1;
                    w_err_nxt   = 1'b0;
                    w_csum_nxt  = '0;
                    w_addr_nxt  = BASE_ADDR;
                end
            end
            LEN: begin
                if (w_xfer) begin
                    w_count_nxt = (in_data == 8'd0) ? DEPTH : CNT_W'(in_data);
                    w_odd_nxt   = in_data[0];
                    w_state_nxt = DATA;
                end
            end
            DATA: begin
                if (w_xfer) begin
                    w_we_nxt    = 1'b1;
                    w_maddr_nxt = r_addr;
                    w_wdata_nxt = in_data;
                    w_csum_nxt  = r_csum ^ in_data;
                    w_addr_nxt  = r_addr + 1'b1;
                    w_count_nxt = r_count - 1'b1;
                    if (r_count == CNT_W'(1))
                        w_state_nxt = CSUM;
                end
            end
            CSUM: begin
                // An odd byte count leaves the final 16-bit instruction half-written.
                if (w_xfer) begin
                    w_err_nxt   = (in_data != r_csum) || r_odd;
                    w_done_nxt  = 1'b1;
                    w_hold_nxt  = 1'b0;
                    w_state_nxt = DONE;
                end
            end
            DONE: begin
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase

        w_in_ready_nxt = (w_state_nxt == LEN) || (w_state_nxt == DATA) ||
                         (w_state_nxt == CSUM);
    end

    assign in_ready  = r_in_ready;
    assign mem_we    = r_we;
    assign mem_addr  = r_maddr;
    assign mem_wdata = r_wdata;
    assign cpu_hold  = r_hold;
    assign done      = r_done;
    assign err       = r_err;

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: frame loads, checksum/odd-length errors,
// address wrap, full-depth frame, mid-frame reset and spurious start.
module tb_imem_loader;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic [7:0] in_data;
    logic       in_valid;

    logic       in_ready, mem_we, cpu_hold, done, err;
    logic [7:0] mem_addr, mem_wdata;
    logic       w_in_ready, w_mem_we, w_cpu_hold, w_done, w_err;
    logic [7:0] w_mem_addr, w_mem_wdata;

    int n_vec = 0;
    int n_bad = 0;

    imem_loader #(.ADDR_W(8), .BASE_ADDR(8'h00)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .in_data(in_data),
        .in_valid(in_valid), .in_ready(in_ready), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .cpu_hold(cpu_hold),
        .done(done), .err(err)
    );

    imem_loader #(.ADDR_W(8), .BASE_ADDR(8'hFE)) dut_w (
        .clk(clk), .rst_n(rst_n), .start(start), .in_data(in_data),
        .in_valid(in_valid), .in_ready(w_in_ready), .mem_we(w_mem_we),
        .mem_addr(w_mem_addr), .mem_wdata(w_mem_wdata), .cpu_hold(w_cpu_hold),
        .done(w_done), .err(w_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Write log and memory image, sampled on the falling edge.
    logic [7:0] mem [256];
    logic [7:0] log_addr [300];
    logic [7:0] log_data [300];
    int         log_cyc  [300];
    int         log_n = 0;
    logic [7:0] wlog_addr [300];
    int         wlog_n = 0;
    int         cyc = 0;

    always @(negedge clk) begin
        cyc++;
        if (mem_we) begin
            mem[mem_addr] = mem_wdata;
            if (log_n < 300) begin
                log_addr[log_n] = mem_addr;
                log_data[log_n] = mem_wdata;
                log_cyc[log_n]  = cyc;
            end
            log_n++;
        end
        if (w_mem_we) begin
            if (wlog_n < 300) wlog_addr[wlog_n] = w_mem_addr;
            wlog_n++;
        end
    end

    task automatic clr_log();
        log_n  = 0;
        wlog_n = 0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic send(input logic [7:0] b);
        int t;
        t = 0;
        in_data  = b;
        in_valid = 1'b1;
        while (in_ready !== 1'b1 && t < 50) begin
            @(posedge clk); #1;
            t++;
        end
        if (t >= 50) begin
            n_vec++;
            n_bad++;
            $display("FAIL send_timeout: in_ready=%b required 1", in_ready);
        end
        @(posedge clk); #1;
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        repeat (n) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic basic_frame(input logic [7:0] cs);
        logic [7:0] fb [8] = '{8'h31, 8'h12, 8'h34, 8'h13, 8'h01, 8'h40, 8'h02, 8'h41};
        send(8'd8);
        for (int i = 0; i < 8; i++) send(fb[i]);
        send(cs);
        in_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; in_valid = 1'b0; in_data = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        n_vec++; if (in_ready !== 1'b0)  begin n_bad++; $display("FAIL rst_in_ready: got %b need 0", in_ready); end
        n_vec++; if (mem_we !== 1'b0)    begin n_bad++; $display("FAIL rst_mem_we: got %b need 0", mem_we); end
        n_vec++; if (mem_addr !== 8'h00) begin n_bad++; $display("FAIL rst_mem_addr: got %h need 00", mem_addr); end
        n_vec++; if (mem_wdata !== 8'h00) begin n_bad++; $display("FAIL rst_mem_wdata: got %h need 00", mem_wdata); end
        n_vec++; if (cpu_hold !== 1'b0)  begin n_bad++; $display("FAIL rst_cpu_hold: got %b need 0", cpu_hold); end
        n_vec++; if (done !== 1'b0)      begin n_bad++; $display("FAIL rst_done: got %b need 0", done); end
        n_vec++; if (err !== 1'b0)       begin n_bad++; $display("FAIL rst_err: got %b need 0", err); end
        n_vec++; if (w_mem_addr !== 8'hFE) begin n_bad++; $display("FAIL rst_base_addr: got %h need fe", w_mem_addr); end
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_basic();
        logic [7:0] fb [8] = '{8'h31, 8'h12, 8'h34, 8'h13, 8'h01, 8'h40, 8'h02, 8'h41};
        int bad;
        clr_log();
        pulse_start();
        n_vec++; if (cpu_hold !== 1'b1) begin n_bad++; $display("FAIL basic_hold_after_start: got %b need 1", cpu_hold); end
        n_vec++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL basic_ready_in_len: got %b need 1", in_ready); end
        basic_frame(8'h06);
        n_vec++; if (done !== 1'b1)     begin n_bad++; $display("FAIL basic_done: got %b need 1", done); end
        n_vec++; if (err !== 1'b0)      begin n_bad++; $display("FAIL basic_err: got %b need 0", err); end
        n_vec++; if (cpu_hold !== 1'b0) begin n_bad++; $display("FAIL basic_hold_released: got %b need 0", cpu_hold); end
        n_vec++; if (log_n !== 8)       begin n_bad++; $display("FAIL basic_write_count: got %0d need 8", log_n); end
        bad = 0;
        for (int i = 0; i < 8 && i < log_n; i++) begin
            if (log_addr[i] !== 8'(i) || log_data[i] !== fb[i]) bad++;
            if (i > 0 && log_cyc[i] !== log_cyc[i-1] + 1) bad++;
        end
        n_vec++; if (bad !== 0) begin n_bad++; $display("FAIL basic_write_seq: got %0d bad writes need 0", bad); end
        n_vec++; if ({mem[0], mem[1]} !== 16'h3112) begin n_bad++; $display("FAIL basic_fetch_pc0: got %h need 3112", {mem[0], mem[1]}); end
        n_vec++; if ({mem[6], mem[7]} !== 16'h0241) begin n_bad++; $display("FAIL basic_fetch_pc6: got %h need 0241", {mem[6], mem[7]}); end
        @(posedge clk); #1;
        n_vec++; if (done !== 1'b0 || in_ready !== 1'b0) begin n_bad++; $display("FAIL basic_back_idle: done=%b ready=%b need 0 0", done, in_ready); end
    endtask

    task automatic test_bad_csum();
        clr_log();
        pulse_start();
        basic_frame(8'h07);
        n_vec++; if (done !== 1'b1) begin n_bad++; $display("FAIL badcs_done: got %b need 1", done); end
        n_vec++; if (err !== 1'b1)  begin n_bad++; $display("FAIL badcs_err: got %b need 1", err); end
        n_vec++; if (log_n !== 8)   begin n_bad++; $display("FAIL badcs_write_count: got %0d need 8", log_n); end
        idle(2);
        n_vec++; if (err !== 1'b1)  begin n_bad++; $display("FAIL badcs_err_sticky: got %b need 1", err); end
        pulse_start();
        n_vec++; if (err !== 1'b0)  begin n_bad++; $display("FAIL badcs_err_cleared: got %b need 0", err); end
        basic_frame(8'h06);
        n_vec++; if (err !== 1'b0 || done !== 1'b1) begin n_bad++; $display("FAIL badcs_good_after: err=%b done=%b need 0 1", err, done); end
        idle(2);
    endtask

    task automatic test_odd_gaps();
        logic [7:0] ob [3] = '{8'hAA, 8'hBB, 8'hCC};
        int bad;
        clr_log();
        pulse_start();
        send(8'd3);
        idle(1);
        for (int i = 0; i < 3; i++) begin
            send(ob[i]);
            idle(1);
        end
        send(8'hDD);
        in_valid = 1'b0;
        n_vec++; if (done !== 1'b1) begin n_bad++; $display("FAIL odd_done: got %b need 1", done); end
        n_vec++; if (err !== 1'b1)  begin n_bad++; $display("FAIL odd_err: got %b need 1", err); end
        n_vec++; if (log_n !== 3)   begin n_bad++; $display("FAIL odd_write_count: got %0d need 3", log_n); end
        bad = 0;
        for (int i = 0; i < 3 && i < log_n; i++) begin
            if (log_addr[i] !== 8'(i) || log_data[i] !== ob[i]) bad++;
            if (i > 0 && log_cyc[i] !== log_cyc[i-1] + 2) bad++;
        end
        n_vec++; if (bad !== 0) begin n_bad++; $display("FAIL odd_write_seq: got %0d bad writes need 0", bad); end
        idle(2);
    endtask

    task automatic test_wrap();
        clr_log();
        pulse_start();
        send(8'd4);
        for (int i = 1; i <= 4; i++) send(8'(i));
        send(8'h04);
        in_valid = 1'b0;
        n_vec++; if (w_done !== 1'b1 || w_err !== 1'b0) begin n_bad++; $display("FAIL wrap_done_err: done=%b err=%b need 1 0", w_done, w_err); end
        n_vec++; if (wlog_n !== 4) begin n_bad++; $display("FAIL wrap_write_count: got %0d need 4", wlog_n); end
        n_vec++; if ({wlog_addr[0], wlog_addr[1], wlog_addr[2], wlog_addr[3]} !== 32'hFEFF0001)
            begin n_bad++; $display("FAIL wrap_addrs: got %h %h %h %h need fe ff 00 01", wlog_addr[0], wlog_addr[1], wlog_addr[2], wlog_addr[3]); end
        idle(2);
    endtask

    task automatic test_full_depth();
        int bad;
        clr_log();
        pulse_start();
        send(8'd0);
        for (int i = 0; i < 256; i++) send(8'(i));
        send(8'h00);
        in_valid = 1'b0;
        n_vec++; if (done !== 1'b1 || err !== 1'b0) begin n_bad++; $display("FAIL full_done_err: done=%b err=%b need 1 0", done, err); end
        n_vec++; if (log_n !== 256) begin n_bad++; $display("FAIL full_write_count: got %0d need 256", log_n); end
        bad = 0;
        for (int i = 0; i < 256 && i < log_n; i++)
            if (log_addr[i] !== 8'(i) || log_data[i] !== 8'(i)) bad++;
        n_vec++; if (bad !== 0) begin n_bad++; $display("FAIL full_write_seq: got %0d bad writes need 0", bad); end
        idle(2);
    endtask

    task automatic test_reset_mid_frame();
        clr_log();
        pulse_start();
        send(8'd4);
        send(8'h5A);
        in_valid = 1'b0;
        pulse_start();
        n_vec++; if (cpu_hold !== 1'b1 || in_ready !== 1'b1) begin n_bad++; $display("FAIL spurious_start: hold=%b ready=%b need 1 1", cpu_hold, in_ready); end
        send(8'hA5);
        in_valid = 1'b0;
        @(posedge clk); #1;
        n_vec++; if (log_n !== 2) begin n_bad++; $display("FAIL mid_write_count: got %0d need 2", log_n); end
        n_vec++; if (log_n >= 2 && (log_addr[1] !== 8'h01 || log_data[1] !== 8'hA5))
            begin n_bad++; $display("FAIL mid_second_write: got %h/%h need 01/a5", log_addr[1], log_data[1]); end
        rst_n = 1'b0;
        #1;
        n_vec++; if (cpu_hold !== 1'b0 || in_ready !== 1'b0 || mem_we !== 1'b0)
            begin n_bad++; $display("FAIL mid_async_reset: hold=%b ready=%b we=%b need 0 0 0", cpu_hold, in_ready, mem_we); end
        n_vec++; if (mem_addr !== 8'h00 || mem_wdata !== 8'h00 || err !== 1'b0 || done !== 1'b0)
            begin n_bad++; $display("FAIL mid_reset_values: addr=%h wdata=%h err=%b done=%b need 00 00 0 0", mem_addr, mem_wdata, err, done); end
        @(posedge clk); #1;
        rst_n = 1'b1;
        in_data = 8'h77; in_valid = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        in_valid = 1'b0;
        n_vec++; if (log_n !== 2 || in_ready !== 1'b0) begin n_bad++; $display("FAIL mid_post_reset_idle: writes=%0d ready=%b need 2 0", log_n, in_ready); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_bad_csum();
        test_odd_gaps();
        test_wrap();
        test_full_depth();
        test_reset_mid_frame();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
